button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
// - Front-end conditioning for the Basys3 push-buttons. Sits directly upstream of risingEdgeDetector.
// - Takes raw asynchronous button pins and synchronises each one into clk.
// - Filters contact bounce per channel with a stability counter.
// - Drives a clean level per button. Each level feeds one risingEdgeDetector `sig` input.
// PARAMETERS
// - WIDTH          5          number of independent button channels (Basys3: U,D,L,R,C)
// - STABLE_CYCLES  1_000_000  consecutive clk cycles input must hold a new value before output follows
//                             (10 ms at 100 MHz); legal range >= 2
// PORTS
// - clk        input   1      system clock (100 MHz on board)
// - rst        input   1      asynchronous, active-high reset
// - btn_in     input   WIDTH  raw button pins, asynchronous to clk, may bounce
// - btn_db     output  WIDTH  debounced level per channel, registered
// - btn_busy   output  WIDTH  1 while that channel is qualifying a change (in a WAIT state)
// BEHAVIOUR
// - Reset:
//   - rst=1 asynchronously clears every flop: sync stages, counters, states.
//   - All channels go to S_LOW, so btn_db=0 and btn_busy=0.
// - Synchroniser: 2-flop chain per bit, btn_in -> s1 -> s2 (btn_sync). No logic between the flops.
// - Per-channel FSM, states {S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT}:
//   - S_LOW:
//     - btn_sync=1 -> S_RISE_WAIT, cnt<=0.
//     - Otherwise stay.
//   - S_RISE_WAIT:
//     - btn_sync=0 -> S_LOW, cnt<=0. The glitch is discarded.
//     - Else if cnt==STABLE_CYCLES-1 -> S_HIGH.
//     - Else cnt<=cnt+1.
//   - S_HIGH: mirror of S_LOW. btn_sync=0 -> S_FALL_WAIT, cnt<=0.
//   - S_FALL_WAIT: mirror of S_RISE_WAIT.
//     - btn_sync=1 -> S_HIGH.
//     - Terminal count -> S_LOW.
// - Outputs:
//   - btn_db is a flop: set on entry to S_HIGH, cleared on entry to S_LOW.
//   - btn_db must not toggle in any WAIT state.
//   - btn_busy = (state is a WAIT state), derived from state flops.
// - Latency:
//   - Input change held stable: btn_db changes on exactly the (STABLE_CYCLES+3)th rising clk edge.
//   - Counting starts with the first edge that samples the new btn_in value into s1.
// - Glitch rejection: any return to the old value before terminal count restarts qualification from zero.
// - Counter:
//   - Width CW=$clog2(STABLE_CYCLES), unsigned.
//   - Never exceeds STABLE_CYCLES-1, so no wrap.
//   - Held at 0 in S_LOW/S_HIGH.
// - Channels are fully independent. Simultaneous presses on several channels qualify in parallel with identical timing.
// - Reset mid-qualification:
//   - Output returns to 0 immediately, with no clk edge required.
//   - A button still held after rst release qualifies again as a fresh rise (STABLE_CYCLES+3 edges).
// - No combinational path from btn_in to any output.
// STRUCTURE
// - Package button_pkg:
//   - typedef enum logic [1:0] db_state_t {S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT}
//   - localparam BTN_COUNT=5
//   - localparam DEBOUNCE_CYCLES_100MHZ_10MS=1_000_000
// - Sub-module debounce_channel:
//   - One bit: synchroniser + FSM + counter.
//   - Parameter STABLE_CYCLES. Ports clk, rst, raw, db, busy.
// - button_debouncer instantiates WIDTH of them in a generate loop. No shared logic between channels.
// TESTING (bench overrides STABLE_CYCLES=16, WIDTH=2; clk 10 ns)
// - Reset: rst=1 with btn_in=2'b11 -> btn_db=0, btn_busy=0 while asserted.
//   After release, btn_db[1:0]=2'b11 on edge 19, btn_busy=1 on edges 3-18.
// - Clean press: btn_in[0] 0->1 held -> btn_db[0] rises on edge 19 after first sample.
//   btn_db[1] stays 0. Release held -> btn_db[0] falls 19 edges later.
// - Bounce: btn_in[0] toggles 1,0,1,0,1 with 5-cycle phases, then stays 1 -> btn_db[0] stays 0 throughout bouncing.
//   Rises exactly 19 edges after the final 0->1.
// - Short glitch: btn_in[0]=1 for 15 cycles then 0 -> btn_db[0] never rises.
//   btn_busy[0] pulses, then returns to 0.
// - Parallel: both channels pressed same cycle -> both btn_db bits rise on the same edge.
//   Channel 1 released during channel 0 qualification does not disturb channel 0.
// - Reset mid-wait: rst asserted async at cnt=8 in S_RISE_WAIT -> btn_db=0, btn_busy=0 before next edge.
//   Button still held -> rise 19 edges after rst release.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and board constants for the push-button conditioning front end.
// Imported by the per-channel debouncer and the multi-channel top.
package button_pkg;

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_RISE_WAIT = 2'd1,
      S_HIGH      = 2'd2,
      S_FALL_WAIT = 2'd3
   } db_state_t;

   localparam int BTN_COUNT                  = 5;
   localparam int DEBOUNCE_CYCLES_100MHZ_10MS = 1_000_000;

endpackage

// File: rtl/button_debouncer_channel.sv
// One button bit: two-flop synchroniser, stability counter and four-state qualifier.
// The output level only moves after the synchronised input has held a new value for STABLE_CYCLES.
module debounce_channel
   import button_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ_10MS
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic db,
   output logic busy
);

   localparam int            CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

   logic          s1;
   logic          s2;
   db_state_t     state;
   logic [CW-1:0] cnt;

   // s1/s2 form a bare synchroniser chain; the FSM only ever looks at s2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= S_LOW;
         cnt   <= '0;
         db    <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         case (state)
            S_LOW: begin
               if (s2) begin
                  state <= S_RISE_WAIT;
                  cnt   <= '0;
               end
            end
            S_RISE_WAIT: begin
               if (!s2) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (cnt == TERM) begin
                  state <= S_HIGH;
                  cnt   <= '0;
                  db    <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HIGH: begin
               if (!s2) begin
                  state <= S_FALL_WAIT;
                  cnt   <= '0;
               end
            end
            S_FALL_WAIT: begin
               if (s2) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (cnt == TERM) begin
                  state <= S_LOW;
                  cnt   <= '0;
                  db    <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_LOW;
               cnt   <= '0;
               db    <= 1'b0;
            end
         endcase
      end
   end

   // Decoded straight from the state flops, so no path from raw reaches it.
   assign busy = (state == S_RISE_WAIT) || (state == S_FALL_WAIT);

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: WIDTH fully independent debounce_channel instances.
// Each btn_db bit is a clean level suitable for a downstream rising-edge detector.
module button_debouncer
   import button_pkg::*;
#(
   parameter int WIDTH         = BTN_COUNT,
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ_10MS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] btn_db,
   output logic [WIDTH-1:0] btn_busy
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_in[i]),
         .db   (btn_db[i]),
         .busy (btn_busy[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with WIDTH=2, STABLE_CYCLES=16: run-length reference model feeding
// a scoreboard queue, plus direct edge-latency, glitch and async-reset checks.
module tb_button_debouncer;

   localparam int W  = 2;
   localparam int SC = 16;
   localparam int LAT = SC + 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] btn_in = '0;
   logic [W-1:0] btn_db;
   logic [W-1:0] btn_busy;

   button_debouncer #(
      .WIDTH         (W),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_db   (btn_db),
      .btn_busy (btn_busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: a level flips once the value seen after synchronisation has differed from it
   // on SC+1 consecutive edges; busy means a differing run is in progress.
   typedef struct packed {
      logic [W-1:0][5:0] run;
      logic [W-1:0]      db;
      logic [W-1:0]      busy;
   } exp_t;

   function automatic exp_t model_step(input logic [W-1:0] seen, input exp_t cur);
      exp_t nx;
      nx = cur;
      for (int i = 0; i < W; i++) begin
         if (seen[i] != cur.db[i]) begin
            nx.run[i] = cur.run[i] + 6'd1;
            if (nx.run[i] == 6'(SC + 1)) begin
               nx.db[i]  = seen[i];
               nx.run[i] = '0;
            end
         end else begin
            nx.run[i] = '0;
         end
         nx.busy[i] = (nx.run[i] != 6'd0);
      end
      return nx;
   endfunction

   logic [W-1:0] m_s1 = '0;
   logic [W-1:0] m_s2 = '0;
   exp_t         m_st = '0;
   exp_t         sb[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 <= '0;
         m_s2 <= '0;
         m_st <= '0;
         sb.delete();
      end else begin
         m_s1 <= btn_in;
         m_s2 <= m_s1;
         m_st <= model_step(m_s2, m_st);
         sb.push_back(model_step(m_s2, m_st));
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) e = sb.pop_front();
      else e = m_st;
      check_val("sb_db", 32'(btn_db), 32'(e.db));
      check_val("sb_busy", 32'(btn_busy), 32'(e.busy));
   end

   // Edges are counted from the first posedge after the caller changed btn_in at a negedge.
   task automatic wait_edges(input logic [W-1:0] mask, input logic [W-1:0] val,
                             output int e0, output int e1);
      bit done;
      e0 = -1;
      e1 = -1;
      done = 1'b0;
      for (int e = 1; e <= 60 && !done; e++) begin
         @(posedge clk);
         #1;
         if (mask[0] && e0 < 0 && btn_db[0] == val[0]) e0 = e;
         if (mask[1] && e1 < 0 && btn_db[1] == val[1]) e1 = e;
         done = (!mask[0] || e0 >= 0) && (!mask[1] || e1 >= 0);
      end
   endtask

   initial begin
      int  e0, e1, r0, f1;
      bit  saw_busy, saw_db;

      // Reset with both buttons held
      #1 rst = 1'b1;
      btn_in = 2'b11;
      repeat (3) @(negedge clk);
      check_val("rst_db", 32'(btn_db), 32'd0);
      check_val("rst_busy", 32'(btn_busy), 32'd0);
      rst = 1'b0;
      wait_edges(2'b11, 2'b11, e0, e1);
      check_val("rst_rise_ch0", 32'(e0), 32'(LAT));
      check_val("rst_rise_ch1", 32'(e1), 32'(LAT));
      @(negedge clk);
      btn_in = 2'b00;
      wait_edges(2'b11, 2'b00, e0, e1);
      check_val("rel_fall_ch0", 32'(e0), 32'(LAT));
      check_val("rel_fall_ch1", 32'(e1), 32'(LAT));

      // Clean press and release on channel 0 only
      repeat (4) @(negedge clk);
      btn_in = 2'b01;
      wait_edges(2'b01, 2'b01, e0, e1);
      check_val("press_ch0", 32'(e0), 32'(LAT));
      check_val("press_ch1_idle", 32'(btn_db[1]), 32'd0);
      @(negedge clk);
      btn_in = 2'b00;
      wait_edges(2'b01, 2'b00, e0, e1);
      check_val("release_ch0", 32'(e0), 32'(LAT));

      // Bounce: 1,0,1,0 in 5-cycle phases, then settle high
      repeat (4) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         btn_in[0] = (p % 2 == 0);
         repeat (5) @(negedge clk);
      end
      check_val("bounce_hold", 32'(btn_db[0]), 32'd0);
      btn_in[0] = 1'b1;
      wait_edges(2'b01, 2'b01, e0, e1);
      check_val("bounce_rise", 32'(e0), 32'(LAT));
      @(negedge clk);
      btn_in = 2'b00;
      repeat (30) @(negedge clk);

      // Short glitch of 15 cycles never qualifies
      btn_in = 2'b01;
      repeat (15) @(negedge clk);
      btn_in = 2'b00;
      saw_busy = 1'b0;
      saw_db = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         saw_busy |= btn_busy[0];
         saw_db |= btn_db[0];
      end
      check_val("glitch_busy_seen", 32'(saw_busy), 32'd1);
      check_val("glitch_no_rise", 32'(saw_db), 32'd0);
      check_val("glitch_busy_end", 32'(btn_busy[0]), 32'd0);

      // Parallel press on both channels
      @(negedge clk);
      btn_in = 2'b11;
      wait_edges(2'b11, 2'b11, e0, e1);
      check_val("par_rise_ch0", 32'(e0), 32'(LAT));
      check_val("par_rise_ch1", 32'(e1), 32'(LAT));
      @(negedge clk);
      btn_in = 2'b00;
      repeat (30) @(negedge clk);

      // Channel 1 held and released while channel 0 qualifies
      btn_in = 2'b10;
      wait_edges(2'b10, 2'b10, e0, e1);
      @(negedge clk);
      btn_in = 2'b11;
      r0 = -1;
      f1 = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e == 6) btn_in[1] = 1'b0;
         if (r0 < 0 && btn_db[0]) r0 = e;
         if (f1 < 0 && !btn_db[1]) f1 = e;
      end
      check_val("indep_rise_ch0", 32'(r0), 32'(LAT));
      check_val("indep_fall_ch1", 32'(f1), 32'(6 + LAT));
      @(negedge clk);
      btn_in = 2'b00;
      repeat (30) @(negedge clk);

      // Async reset in the middle of a rise qualification, ch1 already high
      btn_in = 2'b10;
      wait_edges(2'b10, 2'b10, e0, e1);
      @(negedge clk);
      btn_in = 2'b11;
      repeat (11) @(posedge clk);
      #1;
      check_val("pre_rst_busy", 32'(btn_busy), 32'd1);
      check_val("pre_rst_db", 32'(btn_db), 32'd2);
      #1 rst = 1'b1;
      #1;
      check_val("midrst_db", 32'(btn_db), 32'd0);
      check_val("midrst_busy", 32'(btn_busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_edges(2'b11, 2'b11, e0, e1);
      check_val("post_rst_ch0", 32'(e0), 32'(LAT));
      check_val("post_rst_ch1", 32'(e1), 32'(LAT));

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
